// File: rtl/rename_pkg.sv
// Shared widths, types and constants for the rename map table and its
// checkpoint queue.
package rename_pkg;

    // Bits needed to name one of n physical registers.
    function automatic int preg_bits(input int n);
        return $clog2(n);
    endfunction

    // Bits needed to name one of n checkpoint slots.
    function automatic int ck_bits(input int n);
        return $clog2(n);
    endfunction

    localparam int DEF_NUM_PHYS_REGS    = 64;
    localparam int DEF_CHECKPOINT_COUNT = 8;

    typedef logic [preg_bits(DEF_NUM_PHYS_REGS)-1:0]  preg_t;
    typedef logic [ck_bits(DEF_CHECKPOINT_COUNT)-1:0] ckpt_id_t;

    // Architectural register 0 is hardwired to physical register 0.
    localparam logic [4:0] ARCH_ZERO = 5'd0;

endpackage

// File: rtl/rename_ckpt_checker.sv
// Protocol checks on the rename/checkpoint control inputs.
module rename_ckpt_checker #(
    parameter int CB = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          ck_release,
    input logic          br_mispredict,
    input logic          exc_flush,
    input logic          ren_fire,
    input logic          ren_ready,
    input logic [CB-1:0] br_ckpt_id,
    input logic [CB-1:0] head,
    input logic [CB:0]   ck_count
);

    logic [CB-1:0] dist_s;

    // Age of the restore checkpoint relative to the oldest live one.
    always_comb begin
        dist_s = br_ckpt_id - head;
    end

    a_release_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
        (ck_release && !exc_flush) |-> (ck_count != {(CB+1){1'b0}}));

    a_mispredict_live: assert property (@(posedge clk) disable iff (!rst_n)
        (br_mispredict && !exc_flush) |-> ({1'b0, dist_s} < ck_count));

    a_fire_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (ren_fire && !br_mispredict && !exc_flush) |-> ren_ready);

endmodule

// File: rtl/rename_ckpt_queue.sv
// Circular queue of RAT checkpoints (map + ready bits). It owns head, tail
// and the live count, keeps stored ready bits current with CDB wakeups and
// presents the wakeup-merged image of the checkpoint being restored.
module rename_ckpt_queue
    import rename_pkg::*;
#(
    parameter int RENAME_WIDTH     = 4,
    parameter int NUM_ARCH_REGS    = 32,
    parameter int NUM_PHYS_REGS    = 64,
    parameter int CHECKPOINT_COUNT = 8,
    localparam int PB  = preg_bits(NUM_PHYS_REGS),
    localparam int CB  = ck_bits(CHECKPOINT_COUNT),
    localparam int BRW = $clog2(RENAME_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PHYS_REGS-1:0] wake_vec,
    input  logic                     alloc,
    input  logic [RENAME_WIDTH-1:0]  snap_we,
    input  logic [CB-1:0]            snap_id [RENAME_WIDTH],
    input  logic [PB-1:0]            snap_map [RENAME_WIDTH][NUM_ARCH_REGS],
    input  logic [NUM_ARCH_REGS-1:0] snap_rdy [RENAME_WIDTH],
    input  logic [BRW-1:0]           br_total,
    input  logic                     release_head,
    input  logic                     mispredict,
    input  logic [CB-1:0]            br_id,
    input  logic                     flush,
    output logic [CB-1:0]            head,
    output logic [CB-1:0]            tail,
    output logic [CB:0]              count,
    output logic [PB-1:0]            restore_map [NUM_ARCH_REGS],
    output logic [NUM_ARCH_REGS-1:0] restore_rdy
);

    logic [PB-1:0]            ck_map [CHECKPOINT_COUNT][NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] ck_rdy [CHECKPOINT_COUNT];
    logic                     rel_s;
    logic [CB-1:0]            dist_s;
    logic [CB:0]              add_s;

    // Release only frees a slot when one is live; distance of the restore point from head.
    always_comb begin
        rel_s  = release_head && (count != {(CB+1){1'b0}});
        dist_s = br_id - head;
        if (alloc) begin
            add_s = (CB+1)'(br_total);
        end else begin
            add_s = {(CB+1){1'b0}};
        end
    end

    // Image of the mispredicted branch's checkpoint with this cycle's wakeups folded in.
    always_comb begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            restore_map[r] = ck_map[br_id][r];
            restore_rdy[r] = ck_rdy[br_id][r] | wake_vec[ck_map[br_id][r]];
        end
    end

    // Checkpoint storage, wakeup merge and queue pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= {CB{1'b0}};
            tail  <= {CB{1'b0}};
            count <= {(CB+1){1'b0}};
            for (int c = 0; c < CHECKPOINT_COUNT; c++) begin
                ck_rdy[c] <= {NUM_ARCH_REGS{1'b1}};
                for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                    ck_map[c][r] <= {PB{1'b0}};
                end
            end
        end else begin
            for (int c = 0; c < CHECKPOINT_COUNT; c++) begin
                for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                    if (wake_vec[ck_map[c][r]]) begin
                        ck_rdy[c][r] <= 1'b1;
                    end
                end
            end
            if (flush) begin
                head  <= tail;
                count <= {(CB+1){1'b0}};
            end else if (mispredict) begin
                tail  <= br_id + CB'(1'b1);
                head  <= head + CB'(rel_s);
                count <= {1'b0, dist_s} + (CB+1)'(1'b1) - (CB+1)'(rel_s);
            end else begin
                if (alloc) begin
                    for (int i = 0; i < RENAME_WIDTH; i++) begin
                        if (snap_we[i]) begin
                            // Later writes win over the wakeup loop above; the snapshot is already merged.
                            ck_rdy[snap_id[i]] <= snap_rdy[i];
                            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                                ck_map[snap_id[i]][r] <= snap_map[i][r];
                            end
                        end
                    end
                end
                tail  <= tail + add_s[CB-1:0];
                head  <= head + CB'(rel_s);
                count <= count + add_s - (CB+1)'(rel_s);
            end
        end
    end

endmodule

// File: rtl/rename_map_table_ckpt.sv
// Rename map table: speculative RAT with intra-group forwarding, per-entry
// ready bits with CDB wakeup, committed RAT for exception recovery, and a
// per-branch checkpoint queue for mispredict recovery.
module rename_map_table_ckpt
    import rename_pkg::*;
#(
    parameter int RENAME_WIDTH     = 4,
    parameter int NUM_ARCH_REGS    = 32,
    parameter int NUM_PHYS_REGS    = 64,
    parameter int CHECKPOINT_COUNT = 8,
    parameter int WAKEUP_WIDTH     = 4,
    parameter int COMMIT_WIDTH     = 4,
    localparam int PB  = preg_bits(NUM_PHYS_REGS),
    localparam int CB  = ck_bits(CHECKPOINT_COUNT),
    localparam int BRW = $clog2(RENAME_WIDTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [RENAME_WIDTH-1:0]              ren_valid,
    input  logic [RENAME_WIDTH-1:0][4:0]         ren_rs,
    input  logic [RENAME_WIDTH-1:0][4:0]         ren_rt,
    input  logic [RENAME_WIDTH-1:0][4:0]         ren_dest,
    input  logic [RENAME_WIDTH-1:0]              ren_wr,
    input  logic [RENAME_WIDTH-1:0][PB-1:0]      ren_new_preg,
    input  logic [RENAME_WIDTH-1:0]              ren_is_br,
    input  logic                                 ren_fire,
    output logic                                 ren_ready,
    output logic [RENAME_WIDTH-1:0][PB-1:0]      ren_prs1,
    output logic [RENAME_WIDTH-1:0][PB-1:0]      ren_prs2,
    output logic [RENAME_WIDTH-1:0]              ren_prs1_rdy,
    output logic [RENAME_WIDTH-1:0]              ren_prs2_rdy,
    output logic [RENAME_WIDTH-1:0][PB-1:0]      ren_old_prd,
    output logic [RENAME_WIDTH-1:0][CB-1:0]      ren_ckpt_id,
    input  logic [WAKEUP_WIDTH-1:0]              wb_valid,
    input  logic [WAKEUP_WIDTH-1:0][PB-1:0]      wb_preg,
    input  logic [COMMIT_WIDTH-1:0]              cm_valid,
    input  logic [COMMIT_WIDTH-1:0][4:0]         cm_arch,
    input  logic [COMMIT_WIDTH-1:0][PB-1:0]      cm_preg,
    input  logic                                 ck_release,
    input  logic                                 br_mispredict,
    input  logic [CB-1:0]                        br_ckpt_id,
    input  logic                                 exc_flush,
    output logic [CB:0]                          ck_count
);

    logic [PB-1:0]            rat [NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] rat_rdy;
    logic [PB-1:0]            committed [NUM_ARCH_REGS];
    logic [PB-1:0]            committed_next [NUM_ARCH_REGS];
    logic [NUM_PHYS_REGS-1:0] wake_vec;
    logic [PB-1:0]            map_s [RENAME_WIDTH+1][NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] rdy_s [RENAME_WIDTH+1];
    logic [NUM_ARCH_REGS-1:0] fresh_s [RENAME_WIDTH+1];
    logic [PB-1:0]            snap_map [RENAME_WIDTH][NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] snap_rdy [RENAME_WIDTH];
    logic [CB-1:0]            snap_id [RENAME_WIDTH];
    logic [RENAME_WIDTH-1:0]  snap_we;
    logic [BRW-1:0]           br_total;
    logic [NUM_ARCH_REGS-1:0] fire_rdy_s;
    logic [NUM_ARCH_REGS-1:0] idle_rdy_s;
    logic [PB-1:0]            restore_map [NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] restore_rdy;
    logic [CB-1:0]            head;
    logic [CB-1:0]            tail;
    logic [31:0]              free_s;

    // One-hot of every preg broadcast on the CDB this cycle.
    always_comb begin
        wake_vec = {NUM_PHYS_REGS{1'b0}};
        for (int k = 0; k < WAKEUP_WIDTH; k++) begin
            if (wb_valid[k]) begin
                wake_vec[wb_preg[k]] = 1'b1;
            end
        end
    end

    // Committed RAT including this cycle's commits; the highest port wins.
    always_comb begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            committed_next[r] = committed[r];
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (cm_valid[k] && (cm_arch[k] != ARCH_ZERO)) begin
                committed_next[cm_arch[k]] = cm_preg[k];
            end
        end
    end

    // Slot-by-slot rename: each slot sees the RAT as modified by older slots of the group.
    always_comb begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            map_s[0][r] = rat[r];
        end
        rdy_s[0]   = rat_rdy;
        fresh_s[0] = {NUM_ARCH_REGS{1'b0}};
        br_total   = {BRW{1'b0}};
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            ren_ckpt_id[i] = tail + CB'(br_total);
            snap_id[i]     = tail + CB'(br_total);
            snap_we[i]     = ren_valid[i] & ren_is_br[i];
            if (ren_rs[i] == ARCH_ZERO) begin
                ren_prs1[i]     = {PB{1'b0}};
                ren_prs1_rdy[i] = 1'b1;
            end else begin
                ren_prs1[i]     = map_s[i][ren_rs[i]];
                ren_prs1_rdy[i] = rdy_s[i][ren_rs[i]] | wake_vec[map_s[i][ren_rs[i]]];
            end
            if (ren_rt[i] == ARCH_ZERO) begin
                ren_prs2[i]     = {PB{1'b0}};
                ren_prs2_rdy[i] = 1'b1;
            end else begin
                ren_prs2[i]     = map_s[i][ren_rt[i]];
                ren_prs2_rdy[i] = rdy_s[i][ren_rt[i]] | wake_vec[map_s[i][ren_rt[i]]];
            end
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                map_s[i+1][r] = map_s[i][r];
            end
            rdy_s[i+1]   = rdy_s[i];
            fresh_s[i+1] = fresh_s[i];
            if (ren_valid[i] && ren_wr[i] && (ren_dest[i] != ARCH_ZERO)) begin
                ren_old_prd[i]             = map_s[i][ren_dest[i]];
                map_s[i+1][ren_dest[i]]    = ren_new_preg[i];
                rdy_s[i+1][ren_dest[i]]    = 1'b0;
                fresh_s[i+1][ren_dest[i]]  = 1'b1;
            end else begin
                ren_old_prd[i] = {PB{1'b0}};
            end
            // A mapping created in this group must not be woken by a stale broadcast.
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                snap_map[i][r] = map_s[i+1][r];
                snap_rdy[i][r] = rdy_s[i+1][r] | (wake_vec[map_s[i+1][r]] & ~fresh_s[i+1][r]);
            end
            if (snap_we[i]) begin
                br_total = br_total + BRW'(1'b1);
            end
        end
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            fire_rdy_s[r] = snap_rdy[RENAME_WIDTH-1][r];
            idle_rdy_s[r] = rat_rdy[r] | wake_vec[rat[r]];
        end
        free_s    = 32'(CHECKPOINT_COUNT) - 32'(ck_count);
        ren_ready = (free_s >= 32'(br_total));
    end

    // Live RAT: reset > exception flush > mispredict restore > rename; wakeup always merged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                rat[r] <= PB'(r);
            end
            rat_rdy <= {NUM_ARCH_REGS{1'b1}};
        end else if (exc_flush) begin
            rat     <= committed_next;
            rat_rdy <= {NUM_ARCH_REGS{1'b1}};
        end else if (br_mispredict) begin
            rat     <= restore_map;
            rat_rdy <= restore_rdy;
        end else if (ren_fire) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                rat[r] <= map_s[RENAME_WIDTH][r];
            end
            rat_rdy <= fire_rdy_s;
        end else begin
            rat_rdy <= idle_rdy_s;
        end
    end

    // Committed (architectural) RAT used for exception recovery.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                committed[r] <= PB'(r);
            end
        end else begin
            committed <= committed_next;
        end
    end

    rename_ckpt_queue #(
        .RENAME_WIDTH     (RENAME_WIDTH),
        .NUM_ARCH_REGS    (NUM_ARCH_REGS),
        .NUM_PHYS_REGS    (NUM_PHYS_REGS),
        .CHECKPOINT_COUNT (CHECKPOINT_COUNT)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .wake_vec     (wake_vec),
        .alloc        (ren_fire),
        .snap_we      (snap_we),
        .snap_id      (snap_id),
        .snap_map     (snap_map),
        .snap_rdy     (snap_rdy),
        .br_total     (br_total),
        .release_head (ck_release),
        .mispredict   (br_mispredict),
        .br_id        (br_ckpt_id),
        .flush        (exc_flush),
        .head         (head),
        .tail         (tail),
        .count        (ck_count),
        .restore_map  (restore_map),
        .restore_rdy  (restore_rdy)
    );

    rename_ckpt_checker #(
        .CB (CB)
    ) u_checker (
        .clk           (clk),
        .rst_n         (rst_n),
        .ck_release    (ck_release),
        .br_mispredict (br_mispredict),
        .exc_flush     (exc_flush),
        .ren_fire      (ren_fire),
        .ren_ready     (ren_ready),
        .br_ckpt_id    (br_ckpt_id),
        .head          (head),
        .ck_count      (ck_count)
    );

endmodule

// File: tb/tb_rename_map_table_ckpt.sv
// Scoreboard bench for rename_map_table_ckpt: expectations are queued when a
// group is driven and compared against the selected DUT output afterwards.
module tb_rename_map_table_ckpt;
    import rename_pkg::*;

    localparam int RW = 4;
    localparam int PB = 6;
    localparam int CB = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [RW-1:0]          ren_valid, ren_wr, ren_is_br;
    logic [RW-1:0][4:0]     ren_rs, ren_rt, ren_dest;
    logic [RW-1:0][PB-1:0]  ren_new_preg;
    logic                   ren_fire, ren_ready;
    logic [RW-1:0][PB-1:0]  ren_prs1, ren_prs2, ren_old_prd;
    logic [RW-1:0]          ren_prs1_rdy, ren_prs2_rdy;
    logic [RW-1:0][CB-1:0]  ren_ckpt_id;
    logic [3:0]             wb_valid, cm_valid;
    logic [3:0][PB-1:0]     wb_preg, cm_preg;
    logic [3:0][4:0]        cm_arch;
    logic                   ck_release, br_mispredict, exc_flush;
    logic [CB-1:0]          br_ckpt_id;
    logic [CB:0]            ck_count;

    rename_map_table_ckpt dut (
        .clk(clk), .rst_n(rst_n), .ren_valid(ren_valid), .ren_rs(ren_rs), .ren_rt(ren_rt),
        .ren_dest(ren_dest), .ren_wr(ren_wr), .ren_new_preg(ren_new_preg), .ren_is_br(ren_is_br),
        .ren_fire(ren_fire), .ren_ready(ren_ready), .ren_prs1(ren_prs1), .ren_prs2(ren_prs2),
        .ren_prs1_rdy(ren_prs1_rdy), .ren_prs2_rdy(ren_prs2_rdy), .ren_old_prd(ren_old_prd),
        .ren_ckpt_id(ren_ckpt_id), .wb_valid(wb_valid), .wb_preg(wb_preg), .cm_valid(cm_valid),
        .cm_arch(cm_arch), .cm_preg(cm_preg), .ck_release(ck_release), .br_mispredict(br_mispredict),
        .br_ckpt_id(br_ckpt_id), .exc_flush(exc_flush), .ck_count(ck_count)
    );

    always #5 clk = ~clk;

    typedef enum int {S_PRS1, S_PRS2, S_RDY1, S_RDY2, S_OLD, S_CKID, S_READY, S_COUNT} sel_e;
    typedef struct {
        string tag;
        sel_e  sel;
        int    idx;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input sel_e sel, input int idx);
        case (sel)
            S_PRS1:  return int'(ren_prs1[idx]);
            S_PRS2:  return int'(ren_prs2[idx]);
            S_RDY1:  return int'(ren_prs1_rdy[idx]);
            S_RDY2:  return int'(ren_prs2_rdy[idx]);
            S_OLD:   return int'(ren_old_prd[idx]);
            S_CKID:  return int'(ren_ckpt_id[idx]);
            S_READY: return int'(ren_ready);
            S_COUNT: return int'(ck_count);
            default: return -1;
        endcase
    endfunction

    task automatic expect_out(input string tag, input sel_e sel, input int idx, input int exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.idx = idx; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        ren_valid = '0; ren_wr = '0; ren_is_br = '0; ren_rs = '0; ren_rt = '0;
        ren_dest = '0; ren_new_preg = '0; ren_fire = 1'b0;
        wb_valid = '0; wb_preg = '0; cm_valid = '0; cm_arch = '0; cm_preg = '0;
        ck_release = 1'b0; br_mispredict = 1'b0; exc_flush = 1'b0; br_ckpt_id = '0;
    endtask

    // Compare queued expectations (combinational settle), then advance one clock.
    task automatic cycle();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel, e.idx), e.exp);
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic slot(input int i, input int rs, input int rt, input int dest, input int np, input bit br);
        ren_valid[i]    = 1'b1;
        ren_rs[i]       = 5'(rs);
        ren_rt[i]       = 5'(rt);
        ren_dest[i]     = 5'(dest);
        ren_wr[i]       = (dest != 0);
        ren_new_preg[i] = 6'(np);
        ren_is_br[i]    = br;
    endtask

    task automatic exp_src1(input string tag, input int i, input int preg, input int rdy);
        expect_out($sformatf("%s_prs1_s%0d", tag, i), S_PRS1, i, preg);
        expect_out($sformatf("%s_rdy1_s%0d", tag, i), S_RDY1, i, rdy);
    endtask

    task automatic exp_src2(input string tag, input int i, input int preg, input int rdy);
        expect_out($sformatf("%s_prs2_s%0d", tag, i), S_PRS2, i, preg);
        expect_out($sformatf("%s_rdy2_s%0d", tag, i), S_RDY2, i, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state: identity map, all ready, empty queue.
        do_reset();
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < RW; i++) begin
                slot(i, 4 * g + i, 0, 0, 0, 1'b0);
                exp_src1("rst", i, 4 * g + i, 1);
                exp_src2("rst", i, 0, 1);
            end
            expect_out("rst_count", S_COUNT, 0, 0);
            expect_out("rst_ready", S_READY, 0, 1);
            expect_out("rst_ckid", S_CKID, 0, 0);
            cycle();
        end

        // Intra-group forwarding and old mapping.
        slot(0, 2, 3, 1, 40, 1'b0);
        slot(1, 1, 1, 4, 41, 1'b0);
        ren_fire = 1'b1;
        exp_src1("fwd", 0, 2, 1);
        exp_src2("fwd", 0, 3, 1);
        expect_out("fwd_old_s0", S_OLD, 0, 1);
        exp_src1("fwd", 1, 40, 0);
        exp_src2("fwd", 1, 40, 0);
        expect_out("fwd_old_s1", S_OLD, 1, 4);
        cycle();
        slot(0, 1, 4, 0, 0, 1'b0);
        wb_valid[0] = 1'b1; wb_preg[0] = 6'd40;
        exp_src1("bypass40", 0, 40, 1);
        exp_src2("bypass40", 0, 41, 0);
        expect_out("nowr_old", S_OLD, 0, 0);
        cycle();
        slot(0, 1, 4, 0, 0, 1'b0);
        exp_src1("woke40", 0, 40, 1);
        exp_src2("woke40", 0, 41, 0);
        cycle();

        // Four branches per cycle until full, then release.
        do_reset();
        for (int i = 0; i < RW; i++) slot(i, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < RW; i++) expect_out($sformatf("br_id_a%0d", i), S_CKID, i, i);
        expect_out("br_ready_a", S_READY, 0, 1);
        ren_fire = 1'b1;
        cycle();
        for (int i = 0; i < RW; i++) slot(i, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < RW; i++) expect_out($sformatf("br_id_b%0d", i), S_CKID, i, 4 + i);
        expect_out("br_ready_b", S_READY, 0, 1);
        expect_out("br_count_b", S_COUNT, 0, 4);
        ren_fire = 1'b1;
        cycle();
        slot(0, 0, 0, 0, 0, 1'b1);
        expect_out("full_count", S_COUNT, 0, 8);
        expect_out("full_ready", S_READY, 0, 0);
        expect_out("full_ckid", S_CKID, 0, 0);
        cycle();
        slot(0, 0, 0, 0, 0, 1'b1);
        ck_release = 1'b1;
        expect_out("rel_ready_same", S_READY, 0, 0);
        cycle();
        slot(0, 0, 0, 0, 0, 1'b1);
        expect_out("rel_count", S_COUNT, 0, 7);
        expect_out("rel_ready", S_READY, 0, 1);
        cycle();

        // Mispredict restores a checkpoint whose entry was woken after capture.
        do_reset();
        slot(0, 0, 0, 0, 0, 1'b1);
        slot(1, 0, 0, 0, 0, 1'b1);
        slot(2, 0, 0, 5, 45, 1'b1);
        ren_fire = 1'b1;
        expect_out("mp_ckid2", S_CKID, 2, 2);
        expect_out("mp_old2", S_OLD, 2, 5);
        cycle();
        slot(0, 0, 0, 5, 46, 1'b0);
        ren_fire = 1'b1;
        wb_valid[0] = 1'b1; wb_preg[0] = 6'd45;
        expect_out("mp_old_r5", S_OLD, 0, 45);
        expect_out("mp_count_pre", S_COUNT, 0, 3);
        cycle();
        slot(0, 5, 0, 0, 0, 1'b0);
        slot(1, 0, 0, 6, 50, 1'b1);
        ren_fire = 1'b1;
        br_mispredict = 1'b1; br_ckpt_id = 3'd2;
        exp_src1("mp_live", 0, 46, 0);
        cycle();
        slot(0, 5, 6, 0, 0, 1'b0);
        exp_src1("mp_r5", 0, 45, 1);
        exp_src2("mp_r6", 0, 6, 1);
        expect_out("mp_tail", S_CKID, 0, 3);
        expect_out("mp_count", S_COUNT, 0, 3);
        cycle();

        // Wrapped queue: head=6, tail=2, count=4; mispredict id 7.
        do_reset();
        for (int i = 0; i < RW; i++) slot(i, 0, 0, 0, 0, 1'b1);
        ren_fire = 1'b1;
        cycle();
        slot(0, 0, 0, 0, 0, 1'b1);
        slot(1, 0, 0, 0, 0, 1'b1);
        ren_fire = 1'b1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            ck_release = 1'b1;
            cycle();
        end
        for (int i = 0; i < RW; i++) slot(i, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < RW; i++) expect_out($sformatf("wrap_id%0d", i), S_CKID, i, (6 + i) % 8);
        expect_out("wrap_count_pre", S_COUNT, 0, 0);
        ren_fire = 1'b1;
        cycle();
        br_mispredict = 1'b1; br_ckpt_id = 3'd7;
        expect_out("wrap_count_live", S_COUNT, 0, 4);
        cycle();
        slot(0, 0, 0, 0, 0, 1'b0);
        expect_out("wrap_tail", S_CKID, 0, 0);
        expect_out("wrap_count", S_COUNT, 0, 2);
        cycle();

        // Commit, speculative rename, then exception flush.
        do_reset();
        cm_valid = 4'b1111;
        cm_arch[0] = 5'd7; cm_preg[0] = 6'd50;
        cm_arch[1] = 5'd8; cm_preg[1] = 6'd55;
        cm_arch[2] = 5'd8; cm_preg[2] = 6'd56;
        cm_arch[3] = 5'd0; cm_preg[3] = 6'd60;
        cycle();
        slot(0, 0, 0, 7, 52, 1'b0);
        slot(1, 0, 0, 8, 53, 1'b1);
        ren_fire = 1'b1;
        cycle();
        slot(0, 7, 0, 0, 0, 1'b0);
        exc_flush = 1'b1;
        exp_src1("exc_spec", 0, 52, 0);
        expect_out("exc_count_pre", S_COUNT, 0, 1);
        cycle();
        slot(0, 7, 0, 0, 0, 1'b0);
        slot(1, 8, 0, 0, 0, 1'b0);
        slot(2, 0, 0, 0, 0, 1'b0);
        exp_src1("exc_r7", 0, 50, 1);
        exp_src1("exc_r8", 1, 56, 1);
        exp_src1("exc_r0", 2, 0, 1);
        expect_out("exc_count", S_COUNT, 0, 0);
        cycle();

        // Same-cycle wakeup bypass during a firing group; new dest stays not-ready.
        do_reset();
        slot(0, 0, 0, 9, 33, 1'b0);
        ren_fire = 1'b1;
        cycle();
        slot(0, 9, 0, 10, 34, 1'b0);
        slot(1, 10, 9, 0, 0, 1'b0);
        wb_valid = 4'b0011; wb_preg[0] = 6'd33; wb_preg[1] = 6'd34;
        ren_fire = 1'b1;
        exp_src1("byp33", 0, 33, 1);
        expect_out("byp_fwd34", S_PRS1, 1, 34);
        exp_src2("byp33", 1, 33, 1);
        cycle();
        slot(0, 9, 10, 0, 0, 1'b0);
        exp_src1("after_r9", 0, 33, 1);
        exp_src2("after_r10", 0, 34, 0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_map_table_ckpt.md
Name: rename_map_table_ckpt

Overview:
Parametrised successor rename map table for the OoO MIPS32 core. It renames RENAME_WIDTH instructions per cycle through a speculative RAT with intra-group forwarding, and checkpoints the RAT once per branch, with up to all slots being branches. Checkpoints live in an ordered circular queue: they are freed at commit and truncated on mispredict. The block tracks ready bits through CDB wakeup, applied to the live RAT and to every checkpoint, and keeps a committed RAT for exception recovery. It sits between decode and dispatch, driven by an external free list and the ROB.

Parameters:
RENAME_WIDTH, 4, instructions renamed per cycle
NUM_ARCH_REGS, 32, architectural registers; reg 0 hardwired to preg 0 and always ready
NUM_PHYS_REGS, 64, physical registers; PREG_BITS = clog2
CHECKPOINT_COUNT, 8, checkpoint slots; must be a power of 2; CK_BITS = clog2
WAKEUP_WIDTH, 4, CDB writeback ports per cycle
COMMIT_WIDTH, 4, ROB commit ports per cycle

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ren_valid  in  [RENAME_WIDTH]  slot holds an instruction
ren_rs, ren_rt  in  5 x RENAME_WIDTH  arch source registers
ren_dest  in  5 x RENAME_WIDTH  arch destination register
ren_wr  in  [RENAME_WIDTH]  slot writes ren_dest; ignored when ren_dest==0
ren_new_preg  in  PREG_BITS x RENAME_WIDTH  preg allocated by the free list
ren_is_br  in  [RENAME_WIDTH]  slot needs a checkpoint
ren_fire  in  1  group accepted this cycle; legal only when ren_ready=1
ren_ready  out  1  free checkpoints >= branches in the group
ren_prs1, ren_prs2  out  PREG_BITS x RENAME_WIDTH  physical sources
ren_prs1_rdy, ren_prs2_rdy  out  [RENAME_WIDTH]  source ready bits
ren_old_prd  out  PREG_BITS x RENAME_WIDTH  previous mapping of dest; 0 if no write
ren_ckpt_id  out  CK_BITS x RENAME_WIDTH  checkpoint assigned to a branch slot
wb_valid  in  [WAKEUP_WIDTH]  CDB broadcast valid
wb_preg  in  PREG_BITS x WAKEUP_WIDTH  preg that became ready
cm_valid  in  [COMMIT_WIDTH]  commit port valid
cm_arch  in  5 x COMMIT_WIDTH  committed arch dest
cm_preg  in  PREG_BITS x COMMIT_WIDTH  committed preg
ck_release  in  1  oldest branch committed; free head checkpoint
br_mispredict  in  1  restore to checkpoint br_ckpt_id
br_ckpt_id  in  CK_BITS  checkpoint of the mispredicted branch
exc_flush  in  1  restore committed RAT; drop all checkpoints
ck_count  out  CK_BITS+1  live checkpoints

Behaviour:
- Reset (rst_n=0 at clk edge): RAT[r]=r and committed[r]=r; ready all 1; head=tail=0; ck_count=0. ren_ready=1 once reset completes. Reset mid-operation discards all state.
- Lookup is combinational. Slot i sees mappings from slots j<i. A source arch reg of 0 gives preg 0 with rdy=1. Same-cycle wb_preg matches force the rdy outputs to 1 (bypass).
- ren_ckpt_id[i] = tail + (number of ren_is_br&ren_valid in slots <i), mod CHECKPOINT_COUNT.
- The snapshot for branch slot i contains the RAT and ready bits after slots 0..i are applied.
- ren_ready = (CHECKPOINT_COUNT - ck_count) >= popcount(ren_valid&ren_is_br). Combinational.
- On ren_fire: RAT and checkpoints update at the next edge; tail advances by the branch count; ck_count += branches - ck_release.
- Wakeup: each wb_preg sets the ready bit of every RAT entry and every live checkpoint entry mapping to it. Wakeup applies after rename writes in the same cycle, except that a new dest mapping of this cycle stays not-ready.
- Commit: committed[cm_arch] <= cm_preg for each valid port, in port order (the higher port wins). Commits to arch 0 are ignored.
- ck_release: head++ and ck_count--. Release with ck_count==0 is ignored and fires an assertion.
- Mispredict: RAT <= ckpt[br_ckpt_id] with wakeups merged. tail <= br_ckpt_id+1. ck_count <= ((br_ckpt_id-head) mod C)+1, minus 1 if ck_release is asserted in the same cycle. ren_fire in the same cycle is ignored. br_ckpt_id must be live, otherwise an assertion fires.
- exc_flush: RAT <= committed RAT; all ready=1; head=tail; ck_count=0.
- Priority: rst_n low > exc_flush > br_mispredict > ren_fire. Wakeup and commit are always applied.
- Pointers are CK_BITS wide and wrap naturally. Full: ck_count==C. Empty: ck_count==0.

Decomposition:
- Package rename_pkg: PREG_BITS/CK_BITS helper functions, preg_t and ckpt_id_t typedefs, and the arch-zero constant.
- Sub-module rename_ckpt_queue: holds checkpoint storage, head/tail/count and the wakeup merge. The top-level module holds the RAT, forwarding and committed RAT.

Test Plan:
- Reset, then group {add r1<-r2,r3; add r4<-r1,r1} with new pregs 40,41. Required: slot1 prs1=prs2=40 with rdy=0; slot0 old_prd=1; slot1 old_prd=4.
- Four branches per cycle for two cycles from reset. Required: ids 0-3 then 4-7, ck_count=8. A third group with 1 branch sees ren_ready=0. ck_release in the next cycle brings ren_ready back to 1.
- Branch at id 2 snapshots r5->45. Then wb_preg=45, then br_mispredict id 2. Required: RAT[5]=45 with rdy=1; tail=3; ck_count=3 (head=0).
- With head=6 and tail=2 (wrapped, count 4), mispredict id 7. Required: ck_count=2, tail=0.
- Commit r7->50, rename r7->52, then exc_flush. Required: lookup of r7 gives 50 with rdy=1; ck_count=0.
- Same-cycle ren_fire with a source on preg 33 and wb_preg=33. Required: rdy=1 on the output.
